// File: rtl/decode_stage_riscv_if.sv
// ----------------------------------------------------------------------------
// decode_stage_riscv_if
//   Bundles the fetch-side handshake, the execute-side handshake and the
//   decoded control bundle of the RV32I decode stage.
//
//   Fetch side   : s_valid_i, s_ready_o, s_instr_i[31:0], s_pc_i[31:0]
//   Execute side : m_valid_o, m_ready_i, m_pc_o[31:0]
//   Bundle       : alu_op_o[4:0], a_sel_o[1:0], b_sel_o[1:0], imm_o[31:0],
//                  rs1_o/rs2_o/rd_o[4:0], we_o, mem_req_o, mem_we_o,
//                  branch_o, jal_o, jalr_o, illegal_o, mem_size_o[2:0]
//
//   modport master : the decode stage itself (drives ready and the bundle)
//   modport slave  : the surrounding fetch/execute environment
// ----------------------------------------------------------------------------
interface decode_stage_riscv_if;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [31:0] s_instr_i;
    logic [31:0] s_pc_i;

    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_pc_o;

    logic [4:0]  alu_op_o;
    logic [1:0]  a_sel_o;
    logic [1:0]  b_sel_o;
    logic [31:0] imm_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic        we_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        branch_o;
    logic        jal_o;
    logic        jalr_o;
    logic        illegal_o;
    logic [2:0]  mem_size_o;

    modport master (
        input  s_valid_i, s_instr_i, s_pc_i, m_ready_i,
        output s_ready_o, m_valid_o, m_pc_o,
        output alu_op_o, a_sel_o, b_sel_o, imm_o, rs1_o, rs2_o, rd_o,
        output we_o, mem_req_o, mem_we_o, branch_o, jal_o, jalr_o,
        output illegal_o, mem_size_o
    );

    modport slave (
        output s_valid_i, s_instr_i, s_pc_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_pc_o,
        input  alu_op_o, a_sel_o, b_sel_o, imm_o, rs1_o, rs2_o, rd_o,
        input  we_o, mem_req_o, mem_we_o, branch_o, jal_o, jalr_o,
        input  illegal_o, mem_size_o
    );
endinterface

// File: rtl/decode_stage_riscv.sv
// ----------------------------------------------------------------------------
// decode_stage_riscv
//   RV32I decode stage. Each accepted instruction word is decoded
//   combinationally into a control bundle, and the bundle (never the raw
//   word) is stored in an output register backed by a one-entry skid
//   register. The skid entry lets s_ready_o be a pure register output while
//   still sustaining one instruction per cycle.
//
//   Ports:
//     clk_i    clock, rising edge
//     rst_ni   synchronous reset, active low (drops both held entries)
//     flush_i  discard all held instructions at the next edge
//     bus      decode_stage_riscv_if.master: fetch handshake in, execute
//              handshake and decoded bundle out
//
//   Build option:
//     DECODE_ILLEGAL_CHECK_EN  when defined, unsupported encodings raise
//                              illegal_o and have we_o/mem_req_o forced low;
//                              otherwise illegal_o is 0 and unsupported
//                              encodings decode as ADDI x0,x0,0.
// ----------------------------------------------------------------------------
package alu_opcodes_pkg;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLTS = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_EQ   = 5'd10;
    localparam logic [4:0] ALU_NE   = 5'd11;
    localparam logic [4:0] ALU_LTS  = 5'd12;
    localparam logic [4:0] ALU_GES  = 5'd13;
    localparam logic [4:0] ALU_LTU  = 5'd14;
    localparam logic [4:0] ALU_GEU  = 5'd15;
endpackage

module decode_stage_riscv
    import alu_opcodes_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    decode_stage_riscv_if.master bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu_op;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        mem_req;
        logic        mem_we;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
        logic [2:0]  mem_size;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Shared funct3 -> ALU mapping of OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLTS;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic bundle_t decode(input logic [31:0] instr, input logic [31:0] pc);
        bundle_t           b;
        logic              legal;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic signed [31:0] imm_i;
        logic signed [31:0] imm_s;
        logic signed [31:0] imm_b;
        logic signed [31:0] imm_u;
        logic signed [31:0] imm_j;

        f3 = instr[14:12];
        f7 = instr[31:25];
        // Place each immediate at the top of the word, then arithmetic-shift
        // it down so the sign bit instr[31] is replicated.
        imm_i = $signed({instr[31:20], 20'b0}) >>> 20;
        imm_s = $signed({instr[31:25], instr[11:7], 20'b0}) >>> 20;
        imm_b = $signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0, 19'b0}) >>> 19;
        imm_u = $signed({instr[31:12], 12'b0});
        imm_j = $signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0, 11'b0}) >>> 11;

        b     = '0;
        b.pc  = pc;
        legal = (instr[1:0] == 2'b11);

        case (instr[6:0])
            OPC_OP: begin
                b.rs1    = instr[19:15];
                b.rs2    = instr[24:20];
                b.rd     = instr[11:7];
                b.we     = 1'b1;
                b.a_sel  = A_RS1;
                b.b_sel  = B_RS2;
                b.alu_op = alu_from_f3(f3, f7 == F7_ALT);
                if (!((f7 == F7_ZERO) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                b.rs1    = instr[19:15];
                b.rd     = instr[11:7];
                b.we     = 1'b1;
                b.a_sel  = A_RS1;
                b.b_sel  = B_IMM;
                b.imm    = imm_i;
                // Only the shift-right immediate uses instr[30]; ADDI never becomes SUB.
                b.alu_op = alu_from_f3(f3, (f3 == 3'b101) && instr[30]);
                if ((f3 == 3'b001) && (f7 != F7_ZERO))
                    legal = 1'b0;
                if ((f3 == 3'b101) && (f7 != F7_ZERO) && (f7 != F7_ALT))
                    legal = 1'b0;
            end
            OPC_BRANCH: begin
                b.rs1    = instr[19:15];
                b.rs2    = instr[24:20];
                b.branch = 1'b1;
                b.imm    = imm_b;
                case (f3)
                    3'b000:  b.alu_op = ALU_EQ;
                    3'b001:  b.alu_op = ALU_NE;
                    3'b100:  b.alu_op = ALU_LTS;
                    3'b101:  b.alu_op = ALU_GES;
                    3'b110:  b.alu_op = ALU_LTU;
                    3'b111:  b.alu_op = ALU_GEU;
                    default: legal    = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                b.rs1      = instr[19:15];
                b.rd       = instr[11:7];
                b.we       = 1'b1;
                b.mem_req  = 1'b1;
                b.b_sel    = B_IMM;
                b.imm      = imm_i;
                b.alu_op   = ALU_ADD;
                b.mem_size = f3;
                if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111))
                    legal = 1'b0;
            end
            OPC_STORE: begin
                b.rs1      = instr[19:15];
                b.rs2      = instr[24:20];
                b.mem_req  = 1'b1;
                b.mem_we   = 1'b1;
                b.b_sel    = B_IMM;
                b.imm      = imm_s;
                b.alu_op   = ALU_ADD;
                b.mem_size = f3;
                if (f3[2] || (f3[1:0] == 2'b11))
                    legal = 1'b0;
            end
            OPC_LUI: begin
                b.rd     = instr[11:7];
                b.we     = 1'b1;
                b.a_sel  = A_ZERO;
                b.b_sel  = B_IMM;
                b.imm    = imm_u;
                b.alu_op = ALU_ADD;
            end
            OPC_AUIPC: begin
                b.rd     = instr[11:7];
                b.we     = 1'b1;
                b.a_sel  = A_PC;
                b.b_sel  = B_IMM;
                b.imm    = imm_u;
                b.alu_op = ALU_ADD;
            end
            // Jumps compute the link value pc+4 in the ALU; the target uses imm.
            OPC_JAL: begin
                b.rd     = instr[11:7];
                b.we     = 1'b1;
                b.jal    = 1'b1;
                b.a_sel  = A_PC;
                b.b_sel  = B_FOUR;
                b.imm    = imm_j;
                b.alu_op = ALU_ADD;
            end
            OPC_JALR: begin
                b.rs1    = instr[19:15];
                b.rd     = instr[11:7];
                b.we     = 1'b1;
                b.jalr   = 1'b1;
                b.a_sel  = A_PC;
                b.b_sel  = B_FOUR;
                b.imm    = imm_i;
                b.alu_op = ALU_ADD;
                if (f3 != 3'b000)
                    legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
`ifdef DECODE_ILLEGAL_CHECK_EN
            b.illegal = 1'b1;
            b.we      = 1'b0;
            b.mem_req = 1'b0;
            b.mem_we  = 1'b0;
`else
            // Unsupported encodings become ADDI x0,x0,0.
            b        = '0;
            b.pc     = pc;
            b.we     = 1'b1;
            b.a_sel  = A_RS1;
            b.b_sel  = B_IMM;
            b.alu_op = ALU_ADD;
`endif
        end
        return b;
    endfunction

    state_e  state_q;
    state_e  state_d;
    logic    s_ready_q;
    bundle_t dec_p0;
    bundle_t out_p1;
    bundle_t skid_p1;
    logic    vld_p1;
    logic    accept;
    logic    drain;
    logic    load_out;
    logic    out_from_skid;
    logic    load_skid;

    // ---- p0: combinational decode of the incoming word ----
    assign dec_p0 = decode(bus.s_instr_i, bus.s_pc_i);

    assign vld_p1 = (state_q != ST_EMPTY);
    assign accept = bus.s_valid_i && s_ready_q;
    assign drain  = vld_p1 && bus.m_ready_i;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d  = ST_ONE;
                        load_out = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_d       = ST_ONE;
                        load_out      = 1'b1;
                        out_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_EMPTY;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != ST_TWO);
        end
    end

    // ---- p1: output register and skid register ----
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_p1  <= '0;
            skid_p1 <= '0;
        end else begin
            if (load_out)
                out_p1 <= out_from_skid ? skid_p1 : dec_p0;
            if (load_skid)
                skid_p1 <= dec_p0;
        end
    end

    assign bus.s_ready_o  = s_ready_q;
    assign bus.m_valid_o  = vld_p1;
    assign bus.m_pc_o     = out_p1.pc;
    assign bus.alu_op_o   = out_p1.alu_op;
    assign bus.a_sel_o    = out_p1.a_sel;
    assign bus.b_sel_o    = out_p1.b_sel;
    assign bus.imm_o      = out_p1.imm;
    assign bus.rs1_o      = out_p1.rs1;
    assign bus.rs2_o      = out_p1.rs2;
    assign bus.rd_o       = out_p1.rd;
    assign bus.we_o       = out_p1.we;
    assign bus.mem_req_o  = out_p1.mem_req;
    assign bus.mem_we_o   = out_p1.mem_we;
    assign bus.branch_o   = out_p1.branch;
    assign bus.jal_o      = out_p1.jal;
    assign bus.jalr_o     = out_p1.jalr;
    assign bus.illegal_o  = out_p1.illegal;
    assign bus.mem_size_o = out_p1.mem_size;

endmodule

// File: tb/tb_decode_stage_riscv.sv
// ----------------------------------------------------------------------------
// tb_decode_stage_riscv
//   Directed self-checking bench for decode_stage_riscv. Inputs are driven
//   1 time unit after the rising edge, outputs sampled at the same point.
// ----------------------------------------------------------------------------
module tb_decode_stage_riscv;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_XOR = 5'd5;
    localparam logic [4:0] ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_NE  = 5'd11;

    logic clk_i;
    logic rst_ni;
    logic flush_i;
    int   n_checks;
    int   n_errors;

    decode_stage_riscv_if ifc ();

    decode_stage_riscv dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (ifc.master)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one instruction with m_ready_i=1; returns one cycle later.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        ifc.s_valid_i = 1'b1;
        ifc.s_instr_i = instr;
        ifc.s_pc_i    = pc;
        ifc.m_ready_i = 1'b1;
        tick();
        ifc.s_valid_i = 1'b0;
    endtask

    task automatic idle();
        ifc.s_valid_i = 1'b0;
        ifc.m_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        n_checks++; if (ifc.m_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset.m_valid got %b exp 0", ifc.m_valid_o); end
        n_checks++; if (ifc.s_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset.s_ready got %b exp 1", ifc.s_ready_o); end
        n_checks++; if (ifc.m_pc_o !== 32'h0) begin n_errors++; $display("FAIL reset.m_pc got %h exp 0", ifc.m_pc_o); end
        n_checks++; if (ifc.imm_o !== 32'h0) begin n_errors++; $display("FAIL reset.imm got %h exp 0", ifc.imm_o); end
        n_checks++; if ({ifc.we_o, ifc.mem_req_o, ifc.rd_o, ifc.alu_op_o} !== 12'h0) begin n_errors++; $display("FAIL reset.ctrl got %h exp 0", {ifc.we_o, ifc.mem_req_o, ifc.rd_o, ifc.alu_op_o}); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_add();
        issue(32'h00208133, 32'h0000_1000);
        n_checks++; if (ifc.m_valid_o !== 1'b1) begin n_errors++; $display("FAIL add.m_valid got %b exp 1", ifc.m_valid_o); end
        n_checks++; if (ifc.alu_op_o !== ALU_ADD) begin n_errors++; $display("FAIL add.alu_op got %0d exp %0d", ifc.alu_op_o, ALU_ADD); end
        n_checks++; if ({ifc.rs1_o, ifc.rs2_o, ifc.rd_o} !== {5'd1, 5'd2, 5'd2}) begin n_errors++; $display("FAIL add.regs got %0d/%0d/%0d exp 1/2/2", ifc.rs1_o, ifc.rs2_o, ifc.rd_o); end
        n_checks++; if ({ifc.we_o, ifc.b_sel_o, ifc.a_sel_o} !== 5'b1_00_00) begin n_errors++; $display("FAIL add.we_sel got %b exp 10000", {ifc.we_o, ifc.b_sel_o, ifc.a_sel_o}); end
        n_checks++; if (ifc.m_pc_o !== 32'h0000_1000) begin n_errors++; $display("FAIL add.m_pc got %h exp 00001000", ifc.m_pc_o); end
        // sub x3,x1,x2
        issue(32'h402081B3, 32'h0000_1004);
        n_checks++; if ({ifc.alu_op_o, ifc.rd_o} !== {ALU_SUB, 5'd3}) begin n_errors++; $display("FAIL sub.op_rd got %0d/%0d exp %0d/3", ifc.alu_op_o, ifc.rd_o, ALU_SUB); end
        idle();
    endtask

    task automatic test_op_imm();
        issue(32'hFFF0C093, 32'h0000_2000);
        n_checks++; if (ifc.alu_op_o !== ALU_XOR) begin n_errors++; $display("FAIL xori.alu_op got %0d exp %0d", ifc.alu_op_o, ALU_XOR); end
        n_checks++; if (ifc.b_sel_o !== 2'd1) begin n_errors++; $display("FAIL xori.b_sel got %0d exp 1", ifc.b_sel_o); end
        n_checks++; if (ifc.imm_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL xori.imm got %h exp ffffffff", ifc.imm_o); end
        // srai x4,x4,3
        issue(32'h40325213, 32'h0000_2004);
        n_checks++; if ({ifc.alu_op_o, ifc.rd_o, ifc.rs1_o} !== {ALU_SRA, 5'd4, 5'd4}) begin n_errors++; $display("FAIL srai.op_regs got %0d/%0d/%0d exp %0d/4/4", ifc.alu_op_o, ifc.rd_o, ifc.rs1_o, ALU_SRA); end
        n_checks++; if (ifc.imm_o !== 32'h0000_0403) begin n_errors++; $display("FAIL srai.imm got %h exp 00000403", ifc.imm_o); end
        idle();
    endtask

    task automatic test_branch();
        issue(32'hFE209EE3, 32'h0000_3000);
        n_checks++; if (ifc.alu_op_o !== ALU_NE) begin n_errors++; $display("FAIL bne.alu_op got %0d exp %0d", ifc.alu_op_o, ALU_NE); end
        n_checks++; if ({ifc.branch_o, ifc.we_o} !== 2'b10) begin n_errors++; $display("FAIL bne.branch_we got %b exp 10", {ifc.branch_o, ifc.we_o}); end
        n_checks++; if (ifc.imm_o !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL bne.imm got %h exp fffffffc", ifc.imm_o); end
        idle();
    endtask

    task automatic test_load_store();
        // lw x5,8(x1)
        issue(32'h0080A283, 32'h0000_4000);
        n_checks++; if ({ifc.mem_req_o, ifc.mem_we_o, ifc.we_o, ifc.b_sel_o} !== 5'b101_01) begin n_errors++; $display("FAIL lw.flags got %b exp 10101", {ifc.mem_req_o, ifc.mem_we_o, ifc.we_o, ifc.b_sel_o}); end
        n_checks++; if ({ifc.imm_o, ifc.mem_size_o, ifc.rd_o} !== {32'h8, 3'd2, 5'd5}) begin n_errors++; $display("FAIL lw.imm_size_rd got %h/%0d/%0d exp 8/2/5", ifc.imm_o, ifc.mem_size_o, ifc.rd_o); end
        // sw x2,-4(x1)
        issue(32'hFE20AE23, 32'h0000_4004);
        n_checks++; if ({ifc.mem_req_o, ifc.mem_we_o, ifc.we_o, ifc.alu_op_o} !== {3'b110, ALU_ADD}) begin n_errors++; $display("FAIL sw.flags got %b exp 11000000", {ifc.mem_req_o, ifc.mem_we_o, ifc.we_o, ifc.alu_op_o}); end
        n_checks++; if (ifc.imm_o !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL sw.imm got %h exp fffffffc", ifc.imm_o); end
        idle();
    endtask

    task automatic test_upper_jump();
        // lui x5,0x12345
        issue(32'h123452B7, 32'h0000_5000);
        n_checks++; if ({ifc.a_sel_o, ifc.b_sel_o, ifc.we_o, ifc.rd_o} !== {2'd2, 2'd1, 1'b1, 5'd5}) begin n_errors++; $display("FAIL lui.sel got %0d/%0d/%b/%0d exp 2/1/1/5", ifc.a_sel_o, ifc.b_sel_o, ifc.we_o, ifc.rd_o); end
        n_checks++; if (ifc.imm_o !== 32'h1234_5000) begin n_errors++; $display("FAIL lui.imm got %h exp 12345000", ifc.imm_o); end
        // auipc x6,1
        issue(32'h00001317, 32'h0000_5004);
        n_checks++; if ({ifc.a_sel_o, ifc.b_sel_o, ifc.imm_o} !== {2'd1, 2'd1, 32'h1000}) begin n_errors++; $display("FAIL auipc.sel_imm got %0d/%0d/%h exp 1/1/00001000", ifc.a_sel_o, ifc.b_sel_o, ifc.imm_o); end
        // jal x1,+8
        issue(32'h008000EF, 32'h0000_5008);
        n_checks++; if ({ifc.jal_o, ifc.jalr_o, ifc.we_o, ifc.a_sel_o, ifc.b_sel_o} !== 7'b101_01_10) begin n_errors++; $display("FAIL jal.flags got %b exp 1010110", {ifc.jal_o, ifc.jalr_o, ifc.we_o, ifc.a_sel_o, ifc.b_sel_o}); end
        n_checks++; if ({ifc.imm_o, ifc.rd_o} !== {32'h8, 5'd1}) begin n_errors++; $display("FAIL jal.imm_rd got %h/%0d exp 8/1", ifc.imm_o, ifc.rd_o); end
        // jalr x0,0(x1): we_o stays 1 even with rd=0
        issue(32'h00008067, 32'h0000_500C);
        n_checks++; if ({ifc.jal_o, ifc.jalr_o, ifc.we_o, ifc.rd_o, ifc.rs1_o} !== {3'b011, 5'd0, 5'd1}) begin n_errors++; $display("FAIL jalr.flags got %b/%0d/%0d exp 011/0/1", {ifc.jal_o, ifc.jalr_o, ifc.we_o}, ifc.rd_o, ifc.rs1_o); end
        idle();
    endtask

    task automatic test_illegal();
        issue(32'hFFFF_FFFF, 32'h0000_6000);
        n_checks++; if (ifc.m_valid_o !== 1'b1) begin n_errors++; $display("FAIL illegal.m_valid got %b exp 1", ifc.m_valid_o); end
`ifdef DECODE_ILLEGAL_CHECK_EN
        n_checks++; if ({ifc.illegal_o, ifc.we_o, ifc.mem_req_o} !== 3'b100) begin n_errors++; $display("FAIL illegal.flags got %b exp 100", {ifc.illegal_o, ifc.we_o, ifc.mem_req_o}); end
`else
        n_checks++; if ({ifc.illegal_o, ifc.alu_op_o, ifc.rd_o} !== {1'b0, ALU_ADD, 5'd0}) begin n_errors++; $display("FAIL illegal.nop got %b/%0d/%0d exp 0/%0d/0", ifc.illegal_o, ifc.alu_op_o, ifc.rd_o, ALU_ADD); end
        n_checks++; if ({ifc.b_sel_o, ifc.imm_o, ifc.mem_req_o} !== {2'd1, 32'h0, 1'b0}) begin n_errors++; $display("FAIL illegal.addi got %0d/%h/%b exp 1/0/0", ifc.b_sel_o, ifc.imm_o, ifc.mem_req_o); end
`endif
        idle();
    endtask

    task automatic test_back_to_back();
        ifc.m_ready_i = 1'b0;
        ifc.s_valid_i = 1'b1;
        ifc.s_instr_i = 32'h00100093; ifc.s_pc_i = 32'h0000_7000;   // addi x1,x0,1
        tick();
        n_checks++; if ({ifc.m_valid_o, ifc.s_ready_o} !== 2'b11) begin n_errors++; $display("FAIL b2b.one got %b exp 11", {ifc.m_valid_o, ifc.s_ready_o}); end
        ifc.s_instr_i = 32'h00200113; ifc.s_pc_i = 32'h0000_7004;   // addi x2,x0,2
        tick();
        n_checks++; if (ifc.s_ready_o !== 1'b0) begin n_errors++; $display("FAIL b2b.two_ready got %b exp 0", ifc.s_ready_o); end
        n_checks++; if ({ifc.m_pc_o, ifc.rd_o} !== {32'h7000, 5'd1}) begin n_errors++; $display("FAIL b2b.two_head got %h/%0d exp 00007000/1", ifc.m_pc_o, ifc.rd_o); end
        ifc.s_instr_i = 32'h00300193; ifc.s_pc_i = 32'h0000_7008;   // addi x3,x0,3
        tick();
        n_checks++; if ({ifc.s_ready_o, ifc.m_pc_o} !== {1'b0, 32'h7000}) begin n_errors++; $display("FAIL b2b.hold got %b/%h exp 0/00007000", ifc.s_ready_o, ifc.m_pc_o); end
        ifc.m_ready_i = 1'b1;
        tick();
        n_checks++; if ({ifc.m_valid_o, ifc.s_ready_o, ifc.m_pc_o, ifc.rd_o} !== {2'b11, 32'h7004, 5'd2}) begin n_errors++; $display("FAIL b2b.second got %b%b/%h/%0d exp 11/00007004/2", ifc.m_valid_o, ifc.s_ready_o, ifc.m_pc_o, ifc.rd_o); end
        tick();
        ifc.s_valid_i = 1'b0;
        n_checks++; if ({ifc.m_valid_o, ifc.m_pc_o, ifc.rd_o} !== {1'b1, 32'h7008, 5'd3}) begin n_errors++; $display("FAIL b2b.third got %b/%h/%0d exp 1/00007008/3", ifc.m_valid_o, ifc.m_pc_o, ifc.rd_o); end
        tick();
        n_checks++; if (ifc.m_valid_o !== 1'b0) begin n_errors++; $display("FAIL b2b.empty got %b exp 0", ifc.m_valid_o); end
    endtask

    task automatic test_throughput();
        ifc.m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifc.s_valid_i = 1'b1;
            ifc.s_instr_i = 32'h00000013;
            ifc.s_pc_i    = 32'h0000_8000 + 32'(4 * i);
            tick();
            n_checks++; if ({ifc.m_valid_o, ifc.s_ready_o, ifc.m_pc_o} !== {2'b11, 32'h0000_8000 + 32'(4 * i)}) begin n_errors++; $display("FAIL thru[%0d] got %b%b/%h exp 11/%h", i, ifc.m_valid_o, ifc.s_ready_o, ifc.m_pc_o, 32'h0000_8000 + 32'(4 * i)); end
        end
        idle();
    endtask

    task automatic test_flush();
        ifc.m_ready_i = 1'b0;
        ifc.s_valid_i = 1'b1;
        ifc.s_instr_i = 32'h00100093; ifc.s_pc_i = 32'h0000_9000;
        tick();
        ifc.s_pc_i = 32'h0000_9004;
        tick();
        n_checks++; if (ifc.s_ready_o !== 1'b0) begin n_errors++; $display("FAIL flush.pre_two got %b exp 0", ifc.s_ready_o); end
        flush_i = 1'b1;
        ifc.s_pc_i = 32'h0000_9008;
        tick();
        flush_i = 1'b0;
        ifc.s_valid_i = 1'b0;
        n_checks++; if ({ifc.m_valid_o, ifc.s_ready_o} !== 2'b01) begin n_errors++; $display("FAIL flush.after got %b exp 01", {ifc.m_valid_o, ifc.s_ready_o}); end
        ifc.m_ready_i = 1'b1;
        tick();
        n_checks++; if (ifc.m_valid_o !== 1'b0) begin n_errors++; $display("FAIL flush.not_captured got %b exp 0", ifc.m_valid_o); end
    endtask

    task automatic test_reset_midstream();
        ifc.m_ready_i = 1'b0;
        ifc.s_valid_i = 1'b1;
        ifc.s_instr_i = 32'h00100093; ifc.s_pc_i = 32'h0000_A000;
        tick();
        ifc.s_pc_i = 32'h0000_A004;
        tick();
        ifc.s_valid_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        n_checks++; if ({ifc.m_valid_o, ifc.s_ready_o, ifc.m_pc_o} !== {2'b01, 32'h0}) begin n_errors++; $display("FAIL rstmid.state got %b%b/%h exp 01/00000000", ifc.m_valid_o, ifc.s_ready_o, ifc.m_pc_o); end
        rst_ni = 1'b1;
        ifc.m_ready_i = 1'b1;
        tick();
        n_checks++; if (ifc.m_valid_o !== 1'b0) begin n_errors++; $display("FAIL rstmid.skid_dropped got %b exp 0", ifc.m_valid_o); end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        ifc.s_valid_i = 1'b0;
        ifc.s_instr_i = 32'h0;
        ifc.s_pc_i    = 32'h0;
        ifc.m_ready_i = 1'b0;
        #1;
        test_reset();
        test_add();
        test_op_imm();
        test_branch();
        test_load_store();
        test_upper_jump();
        test_illegal();
        test_back_to_back();
        test_throughput();
        test_flush();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_riscv.md
DECODE_STAGE_RISCV -- requirements
Module: decode_stage_riscv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; it SHALL have no parameters.
REQ-002 clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_ni  input  1  synchronous reset, active low.
REQ-004 flush_i  input  1  discard all held instructions.
REQ-005 s_valid_i  input  1  fetch instruction valid.
REQ-006 s_ready_o  output  1  decode stage can accept an instruction.
REQ-007 s_instr_i  input  32  RV32I instruction word.
REQ-008 s_pc_i  input  32  PC of the instruction.
REQ-009 m_valid_o  output  1  decoded bundle valid.
REQ-010 m_ready_i  input  1  execute stage accepts the bundle.
REQ-011 m_pc_o  output  32  PC of the decoded instruction.
REQ-012 alu_op_o  output  5  ALU operation code, using the alu_opcodes_pkg encodings.
REQ-013 a_sel_o  output  2  ALU operand A source: 0=rs1, 1=PC, 2=zero.
REQ-014 b_sel_o  output  2  ALU operand B source: 0=rs2, 1=imm, 2=const 4.
REQ-015 imm_o  output  32  sign-extended immediate in I/S/B/U/J format.
REQ-016 rs1_o, rs2_o, rd_o  output  5 each  register indices.
REQ-017 we_o, mem_req_o, mem_we_o, branch_o, jal_o, jalr_o, illegal_o  output  1 each  control flags.
REQ-018 mem_size_o  output  3  funct3 of load/store.

Function
REQ-019 Handshake: a transfer SHALL occur on s_valid_i&&s_ready_o or on m_valid_o&&m_ready_i; payload SHALL be held stable while m_valid_o&&!m_ready_i.
REQ-020 Latency: an accepted instruction SHALL appear at m_valid_o one cycle later if the output register is empty or drains in the same cycle.
REQ-021 Storage: an output register plus a one-entry skid register; states EMPTY, ONE, TWO.
REQ-022 EMPTY->ONE on accept; ONE->ONE on accept and drain; ONE->EMPTY on drain without accept; ONE->TWO on accept without drain (the decoded bundle goes into the skid register); TWO->ONE on drain (skid moves to output).
REQ-023 s_ready_o SHALL come directly from a register and SHALL be 0 only in state TWO; full throughput (one instruction per cycle) SHALL be sustained while m_ready_i=1.
REQ-024 Decoding SHALL happen before storage; stored entries SHALL hold decoded bundles, not raw words.
REQ-025 OP/OP-IMM SHALL map funct3/funct7 to ALU_ADD/SUB/SLL/SLTS/SLTU/XOR/SRL/SRA/OR/AND, with a_sel=0 and b_sel=0 or 1; for OP-IMM, SUB SHALL NOT be produced.
REQ-026 BRANCH SHALL map funct3 to ALU_EQ/NE/LTS/GES/LTU/GEU and set branch_o=1 and we_o=0.
REQ-027 LOAD/STORE SHALL use ALU_ADD, b_sel=1 and mem_req_o=1; STORE SHALL set mem_we_o=1 and we_o=0.
REQ-028 LUI SHALL use a_sel=2, b_sel=1, ALU_ADD; AUIPC SHALL use a_sel=1, b_sel=1, ALU_ADD.
REQ-029 JAL/JALR SHALL use a_sel=1, b_sel=2, ALU_ADD, we_o=1 and set jal_o or jalr_o respectively.
REQ-030 For any decode with rd=0, we_o SHALL still follow the opcode; the register file ignores x0.
REQ-031 flush_i=1 SHALL force the state to EMPTY at the next edge; flush SHALL take priority over a simultaneous accept, and s_ready_o SHALL be 1 the cycle after.

Reset
REQ-032 While rst_ni=0 at an edge: state SHALL become EMPTY, m_valid_o=0, s_ready_o=1, all bundle outputs 0; reset mid-stream SHALL drop both held entries.

Configuration
REQ-033 With DECODE_ILLEGAL_CHECK_EN defined: an unsupported opcode, funct3 or funct7, or instr[1:0]!=2'b11, SHALL set illegal_o=1 and force we_o=0 and mem_req_o=0 while still flowing through the handshake.
REQ-034 Without DECODE_ILLEGAL_CHECK_EN: illegal_o SHALL be constant 0, and unsupported encodings SHALL decode as ADDI x0,x0,0.

Verification
REQ-035 0x00208133 (add x2,x1,x2) with m_ready_i=1 -> next cycle m_valid_o=1, alu_op=ALU_ADD, rs1=1, rs2=2, rd=2, we_o=1.
REQ-036 0xFFF0C093 (xori x1,x1,-1) -> alu_op=ALU_XOR, b_sel=1, imm_o=0xFFFFFFFF.
REQ-037 Back-to-back 3 instructions with m_ready_i=0 -> state TWO after 2 accepts, s_ready_o=0, third held at input; raise m_ready_i -> bundles emerge in order, no loss or duplication.
REQ-038 0xFE209EE3 (bne x1,x2,-4) -> alu_op=ALU_NE, branch_o=1, we_o=0, imm_o=0xFFFFFFFC.
REQ-039 State TWO plus flush_i=1 together with s_valid_i=1 -> next cycle m_valid_o=0, s_ready_o=1, the new instruction is not captured.
REQ-040 0xFFFFFFFF with DECODE_ILLEGAL_CHECK_EN -> illegal_o=1, we_o=0; without the macro -> illegal_o=0, decoded as ALU_ADD, rd=0.
